burst_slave: RTL and testbench

Responder end of the team's simplified AXI-style burst bus; serves the master's read channel (AR/R) and write channel (AW/W/B) against an internal byte memory. Read and write paths are independent FSMs sharing one memory. Packed bus formats are the master-side ones: AR = {addr[7:0], len[3:0], id[3:0]}, AW = {addr[7:0], id[3:0]}, R = {data[7:0], resp}.

---
 rtl/burst_bus_pkg.sv | 59 +++++
 rtl/burst_slave_if.sv | 38 +++
 rtl/burst_slave_mem.sv | 25 ++
 rtl/burst_slave.sv | 238 +++++++++++++++++++++++
 tb/tb_burst_slave.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/burst_bus_pkg.sv
// Shared field widths, response codes, FSM encodings and bus layouts
// for the simplified AXI-style burst bus (AR/R, AW/W/B channels).
package burst_bus_pkg;

    localparam int ADDR_W = 8;
    localparam int LEN_W  = 4;
    localparam int ID_W   = 4;
    localparam int DATA_W = 8;

    localparam int AR_W = ADDR_W + LEN_W + ID_W;
    localparam int AW_W = ADDR_W + ID_W;
    localparam int R_W  = DATA_W + 1;
    localparam int B_W  = ID_W + 1;

    localparam logic RESP_OKAY   = 1'b0;
    localparam logic RESP_SLVERR = 1'b1;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    // AR = {addr, len, id}
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [ID_W-1:0]   id;
    } ar_t;

    // AW = {addr, id}
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
    } aw_t;

    // R = {data, resp}
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              resp;
    } r_t;

    // B = {id, err}
    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            err;
    } b_t;

    function automatic logic in_range(logic [ADDR_W-1:0] a,
                                      int unsigned depth);
        return 32'(a) < depth;
    endfunction

endpackage

// File: rtl/burst_slave_if.sv
// Burst bus bundle: AR/R read channel and AW/W/B write channel.
// master drives VALIDs/payloads and R/B READYs; slave the rest.
interface burst_slave_if;
    import burst_bus_pkg::*;

    logic            ARVALID;
    logic [AR_W-1:0] AR;
    logic            ARREADY;
    logic            RVALID;
    logic            RREADY;
    logic [R_W-1:0]  RDATA_OUT;
    logic            RLAST;
    logic            AWVALID;
    logic [AW_W-1:0] AW;
    logic            AWREADY;
    logic            WVALID;
    logic [DATA_W-1:0] WDATA;
    logic            WLAST;
    logic            WREADY;
    logic            BVALID;
    logic            BREADY;
    logic [B_W-1:0]  BRESP;

    modport master (
        output ARVALID, AR, RREADY, AWVALID, AW,
               WVALID, WDATA, WLAST, BREADY,
        input  ARREADY, RVALID, RDATA_OUT, RLAST,
               AWREADY, WREADY, BVALID, BRESP
    );

    modport slave (
        input  ARVALID, AR, RREADY, AWVALID, AW,
               WVALID, WDATA, WLAST, BREADY,
        output ARREADY, RVALID, RDATA_OUT, RLAST,
               AWREADY, WREADY, BVALID, BRESP
    );

endinterface

// File: rtl/burst_slave_mem.sv
// Byte RAM: one synchronous write port, one combinational read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module burst_slave_mem #(
    parameter int unsigned MEM_DEPTH = 128,
    parameter int          IDX_W     = 7
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [7:0]       wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [7:0]       rdata
);

    logic [7:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/burst_slave.sv
// Burst bus responder: independent read and write FSMs over one byte RAM.
// Ports: clk, rst (async, active-low), bus (burst_slave_if.slave).
module burst_slave
    import burst_bus_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 128,
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic          clk,
    input  logic          rst,
    burst_slave_if.slave  bus
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int WC_W  = $clog2(MAX_BEATS + 1);

    ar_t ar;
    aw_t aw;
    assign ar = ar_t'(bus.AR);
    assign aw = aw_t'(bus.AW);

    // Read channel state
    r_state_e          r_state, r_state_n;
    logic [ADDR_W-1:0] r_addr, r_addr_n;
    logic [LEN_W-1:0]  r_len, r_len_n;
    logic [LEN_W-1:0]  r_cnt, r_cnt_n;
    logic              arready_q, arready_n;
    logic              rvalid_q, rvalid_n;
    logic              rlast_q, rlast_n;
    r_t                rdata_q, rdata_n;

    // Write channel state
    w_state_e          w_state, w_state_n;
    logic [ADDR_W-1:0] w_addr, w_addr_n;
    logic [ID_W-1:0]   w_id, w_id_n;
    logic              w_err, w_err_n;
    logic [WC_W-1:0]   w_cnt, w_cnt_n;
    logic              awready_q, awready_n;
    logic              wready_q, wready_n;
    logic              bvalid_q, bvalid_n;
    b_t                bresp_q, bresp_n;

    logic              w_hs;
    logic              w_we;
    logic              w_last;
    logic              err_v;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] mem_rdata;

    assign w_hs = bus.WVALID & wready_q;
    assign w_we = w_hs & in_range(w_addr, MEM_DEPTH);

    // The beat about to be registered: AR address when idle, else the
    // next sequential address.
    assign rd_addr = (r_state == R_IDLE) ? ar.addr : r_addr + 8'd1;

    burst_slave_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_W     (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_addr[IDX_W-1:0]),
        .wdata (bus.WDATA),
        .raddr (rd_addr[IDX_W-1:0]),
        .rdata (mem_rdata)
    );

    // Read data is registered so a held beat stays stable. A write landing
    // on the same edge on the byte being fetched is forwarded so the next
    // beat already sees the new value.
    function automatic r_t fetch(logic [ADDR_W-1:0] a);
        r_t r;
        if (in_range(a, MEM_DEPTH)) begin
            r.data = (w_we && w_addr == a) ? bus.WDATA : mem_rdata;
            r.resp = RESP_OKAY;
        end else begin
            r.data = '0;
            r.resp = RESP_SLVERR;
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= R_IDLE;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            r_state   <= r_state_n;
            r_addr    <= r_addr_n;
            r_len     <= r_len_n;
            r_cnt     <= r_cnt_n;
            arready_q <= arready_n;
            rvalid_q  <= rvalid_n;
            rlast_q   <= rlast_n;
            rdata_q   <= rdata_n;
        end
    end

    always_comb begin
        r_state_n = r_state;
        r_addr_n  = r_addr;
        r_len_n   = r_len;
        r_cnt_n   = r_cnt;
        arready_n = arready_q;
        rvalid_n  = rvalid_q;
        rlast_n   = rlast_q;
        rdata_n   = rdata_q;
        unique case (r_state)
            R_IDLE: begin
                arready_n = 1'b1;
                if (bus.ARVALID && arready_q) begin
                    r_addr_n  = ar.addr;
                    r_len_n   = ar.len;
                    r_cnt_n   = '0;
                    arready_n = 1'b0;
                    rvalid_n  = 1'b1;
                    rlast_n   = (ar.len == '0);
                    rdata_n   = fetch(rd_addr);
                    r_state_n = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && bus.RREADY) begin
                    if (rlast_q) begin
                        rvalid_n  = 1'b0;
                        rlast_n   = 1'b0;
                        rdata_n   = '0;
                        arready_n = 1'b1;
                        r_state_n = R_IDLE;
                    end else begin
                        r_addr_n = rd_addr;
                        r_cnt_n  = r_cnt + 4'd1;
                        rlast_n  = ((r_cnt + 4'd1) == r_len);
                        rdata_n  = fetch(rd_addr);
                    end
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state   <= W_IDLE;
            w_addr    <= '0;
            w_id      <= '0;
            w_err     <= 1'b0;
            w_cnt     <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
        end else begin
            w_state   <= w_state_n;
            w_addr    <= w_addr_n;
            w_id      <= w_id_n;
            w_err     <= w_err_n;
            w_cnt     <= w_cnt_n;
            awready_q <= awready_n;
            wready_q  <= wready_n;
            bvalid_q  <= bvalid_n;
            bresp_q   <= bresp_n;
        end
    end

    always_comb begin
        w_state_n = w_state;
        w_addr_n  = w_addr;
        w_id_n    = w_id;
        w_err_n   = w_err;
        w_cnt_n   = w_cnt;
        awready_n = awready_q;
        wready_n  = wready_q;
        bvalid_n  = bvalid_q;
        bresp_n   = bresp_q;
        w_last    = 1'b0;
        err_v     = w_err;
        unique case (w_state)
            W_IDLE: begin
                awready_n = 1'b1;
                if (bus.AWVALID && awready_q) begin
                    w_addr_n  = aw.addr;
                    w_id_n    = aw.id;
                    w_err_n   = 1'b0;
                    w_cnt_n   = '0;
                    awready_n = 1'b0;
                    wready_n  = 1'b1;
                    w_state_n = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    w_addr_n = w_addr + 8'd1;
                    w_cnt_n  = w_cnt + 1'b1;
                    err_v    = w_err | ~in_range(w_addr, MEM_DEPTH);
                    // Beat cap: a burst reaching MAX_BEATS without WLAST
                    // is cut off and flagged.
                    w_last = bus.WLAST
                           | ((32'(w_cnt) + 32'd1) == MAX_BEATS);
                    if (w_last) begin
                        err_v     = err_v | ~bus.WLAST;
                        wready_n  = 1'b0;
                        bvalid_n  = 1'b1;
                        bresp_n   = '{id: w_id, err: err_v};
                        w_state_n = W_RESP;
                    end
                    w_err_n = err_v;
                end
            end
            W_RESP: begin
                if (bus.BREADY) begin
                    bvalid_n  = 1'b0;
                    bresp_n   = '0;
                    awready_n = 1'b1;
                    w_state_n = W_IDLE;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    assign bus.ARREADY   = arready_q;
    assign bus.RVALID    = rvalid_q;
    assign bus.RLAST     = rlast_q;
    assign bus.RDATA_OUT = rdata_q;
    assign bus.AWREADY   = awready_q;
    assign bus.WREADY    = wready_q;
    assign bus.BVALID    = bvalid_q;
    assign bus.BRESP     = bresp_q;

endmodule

// File: tb/tb_burst_slave.sv
// Directed bench for burst_slave: two instances (MEM_DEPTH 128 and 256)
// driven cycle by cycle, outputs checked 1 time unit after each edge.
module tb_burst_slave;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    burst_slave_if b0 ();
    burst_slave_if b1 ();

    burst_slave #(.MEM_DEPTH(128), .MAX_BEATS(16)) d0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    burst_slave #(.MEM_DEPTH(256), .MAX_BEATS(16)) d1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        b0.ARVALID = 0; b0.AR = '0; b0.RREADY = 0;
        b0.AWVALID = 0; b0.AW = '0; b0.WVALID = 0;
        b0.WDATA = '0; b0.WLAST = 0; b0.BREADY = 0;
        b1.ARVALID = 0; b1.AR = '0; b1.RREADY = 0;
        b1.AWVALID = 0; b1.AW = '0; b1.WVALID = 0;
        b1.WDATA = '0; b1.WLAST = 0; b1.BREADY = 0;

        // Reset state
        tick; tick;
        chk("rst_arready", 32'(b0.ARREADY), 0);
        chk("rst_awready", 32'(b0.AWREADY), 0);
        chk("rst_rvalid", 32'(b0.RVALID), 0);
        chk("rst_wready", 32'(b0.WREADY), 0);
        chk("rst_bvalid", 32'(b0.BVALID), 0);
        chk("rst_rdata", 32'(b0.RDATA_OUT), 0);
        rst = 1'b1;
        tick;
        chk("idle_arready", 32'(b0.ARREADY), 1);
        chk("idle_awready", 32'(b0.AWREADY), 1);

        // Write 0x10: A1 B2 C3, id 3
        b0.AWVALID = 1; b0.AW = {8'h10, 4'd3};
        tick;
        chk("w1_wready", 32'(b0.WREADY), 1);
        chk("w1_awready", 32'(b0.AWREADY), 0);
        b0.AWVALID = 0; b0.WVALID = 1; b0.WDATA = 8'hA1; b0.BREADY = 1;
        tick;
        b0.WDATA = 8'hB2;
        tick;
        chk("w1_no_b_yet", 32'(b0.BVALID), 0);
        b0.WDATA = 8'hC3; b0.WLAST = 1;
        tick;
        chk("w1_bvalid", 32'(b0.BVALID), 1);
        chk("w1_bresp", 32'(b0.BRESP), 32'h06);
        chk("w1_wready_off", 32'(b0.WREADY), 0);
        b0.WVALID = 0; b0.WLAST = 0;
        tick;
        chk("w1_b_done", 32'(b0.BVALID), 0);
        chk("w1_awready_back", 32'(b0.AWREADY), 1);
        b0.BREADY = 0;

        // Read back 0x10 len 2, RREADY held
        b0.ARVALID = 1; b0.AR = {8'h10, 4'd2, 4'd3}; b0.RREADY = 1;
        tick;
        chk("r1_rvalid", 32'(b0.RVALID), 1);
        chk("r1_arready", 32'(b0.ARREADY), 0);
        chk("r1_b0", 32'(b0.RDATA_OUT), 32'h142);
        chk("r1_b0_last", 32'(b0.RLAST), 0);
        b0.ARVALID = 0;
        tick;
        chk("r1_b1", 32'(b0.RDATA_OUT), 32'h164);
        chk("r1_b1_last", 32'(b0.RLAST), 0);
        tick;
        chk("r1_b2", 32'(b0.RDATA_OUT), 32'h186);
        chk("r1_b2_last", 32'(b0.RLAST), 1);
        tick;
        chk("r1_end_rvalid", 32'(b0.RVALID), 0);
        chk("r1_end_rlast", 32'(b0.RLAST), 0);
        chk("r1_end_arready", 32'(b0.ARREADY), 1);
        b0.RREADY = 0;

        // Write 0x7E: 5A 6B, id 1
        b0.AWVALID = 1; b0.AW = {8'h7E, 4'd1}; b0.BREADY = 1;
        tick;
        b0.AWVALID = 0; b0.WVALID = 1; b0.WDATA = 8'h5A;
        tick;
        b0.WDATA = 8'h6B; b0.WLAST = 1;
        tick;
        chk("w2_bresp", 32'(b0.BRESP), 32'h02);
        chk("w2_bvalid", 32'(b0.BVALID), 1);
        b0.WVALID = 0; b0.WLAST = 0;
        tick;
        b0.BREADY = 0;

        // Read 0x7E len 3 crossing MEM_DEPTH, RREADY toggled
        b0.ARVALID = 1; b0.AR = {8'h7E, 4'd3, 4'd0};
        tick;
        chk("r2_7e", 32'(b0.RDATA_OUT), 32'h0B4);
        b0.ARVALID = 0;
        tick;
        chk("r2_7e_hold", 32'(b0.RDATA_OUT), 32'h0B4);
        chk("r2_7e_hold_v", 32'(b0.RVALID), 1);
        b0.RREADY = 1;
        tick;
        chk("r2_7f", 32'(b0.RDATA_OUT), 32'h0D6);
        b0.RREADY = 0;
        tick;
        chk("r2_7f_hold", 32'(b0.RDATA_OUT), 32'h0D6);
        b0.RREADY = 1;
        tick;
        chk("r2_80", 32'(b0.RDATA_OUT), 32'h001);
        chk("r2_80_last", 32'(b0.RLAST), 0);
        b0.RREADY = 0;
        tick;
        chk("r2_80_hold", 32'(b0.RDATA_OUT), 32'h001);
        b0.RREADY = 1;
        tick;
        chk("r2_81", 32'(b0.RDATA_OUT), 32'h001);
        chk("r2_81_last", 32'(b0.RLAST), 1);
        tick;
        chk("r2_end", 32'(b0.RVALID), 0);
        b0.RREADY = 0;

        // Address wrap on the 256-byte instance
        b1.AWVALID = 1; b1.AW = {8'hFF, 4'd2}; b1.BREADY = 1;
        tick;
        b1.AWVALID = 0; b1.WVALID = 1; b1.WDATA = 8'h11;
        tick;
        b1.WDATA = 8'h22; b1.WLAST = 1;
        tick;
        chk("wrap_bresp", 32'(b1.BRESP), 32'h04);
        chk("wrap_bvalid", 32'(b1.BVALID), 1);
        b1.WVALID = 0; b1.WLAST = 0;
        tick;
        b1.BREADY = 0;
        b1.ARVALID = 1; b1.AR = {8'hFF, 4'd1, 4'd2}; b1.RREADY = 1;
        tick;
        chk("wrap_rd_ff", 32'(b1.RDATA_OUT), 32'h022);
        b1.ARVALID = 0;
        tick;
        chk("wrap_rd_00", 32'(b1.RDATA_OUT), 32'h044);
        chk("wrap_rd_last", 32'(b1.RLAST), 1);
        tick;
        b1.RREADY = 0;

        // 16 beats without WLAST: forced end, err
        b0.AWVALID = 1; b0.AW = {8'h20, 4'd5};
        tick;
        b0.AWVALID = 0; b0.WVALID = 1;
        for (int i = 0; i < 16; i++) begin
            b0.WDATA = 8'h40 + 8'(i);
            tick;
            if (i == 14) begin
                chk("max_wready_15", 32'(b0.WREADY), 1);
            end
        end
        chk("max_wready_off", 32'(b0.WREADY), 0);
        chk("max_bvalid", 32'(b0.BVALID), 1);
        chk("max_bresp", 32'(b0.BRESP), 32'h0B);
        b0.WDATA = 8'hEE;
        tick;
        chk("max_17_ignored", 32'(b0.WREADY), 0);
        chk("max_b_held", 32'(b0.BRESP), 32'h0B);
        b0.BREADY = 1;
        tick;
        chk("max_b_done", 32'(b0.BVALID), 0);
        b0.BREADY = 0;
        tick;
        chk("idle_wvalid_ignored", 32'(b0.WREADY), 0);
        b0.WVALID = 0;
        b0.ARVALID = 1; b0.AR = {8'h20, 4'd1, 4'd7}; b0.RREADY = 1;
        tick;
        chk("max_rd_20", 32'(b0.RDATA_OUT), 32'h080);
        b0.ARVALID = 0;
        tick;
        chk("max_rd_21", 32'(b0.RDATA_OUT), 32'h082);
        tick;
        b0.ARVALID = 1; b0.AR = {8'h2F, 4'd0, 4'd0};
        tick;
        chk("len0_data", 32'(b0.RDATA_OUT), 32'h09E);
        chk("len0_last", 32'(b0.RLAST), 1);
        b0.ARVALID = 0;
        tick;
        chk("len0_end", 32'(b0.RVALID), 0);

        // Concurrent read and write, then reset mid-burst
        b0.ARVALID = 1; b0.AR = {8'h10, 4'd2, 4'd1};
        b0.AWVALID = 1; b0.AW = {8'h40, 4'd6};
        tick;
        chk("cc_r_b0", 32'(b0.RDATA_OUT), 32'h142);
        chk("cc_wready", 32'(b0.WREADY), 1);
        b0.ARVALID = 0; b0.AWVALID = 0;
        b0.WVALID = 1; b0.WDATA = 8'h77;
        tick;
        chk("cc_r_b1", 32'(b0.RDATA_OUT), 32'h164);
        rst = 1'b0;
        #1;
        chk("arst_rvalid", 32'(b0.RVALID), 0);
        chk("arst_rlast", 32'(b0.RLAST), 0);
        chk("arst_arready", 32'(b0.ARREADY), 0);
        chk("arst_wready", 32'(b0.WREADY), 0);
        b0.WVALID = 0; b0.RREADY = 0;
        tick;
        rst = 1'b1;
        tick;
        chk("rel_arready", 32'(b0.ARREADY), 1);
        chk("rel_awready", 32'(b0.AWREADY), 1);
        chk("rel_no_b", 32'(b0.BVALID), 0);
        b0.ARVALID = 1; b0.AR = {8'h40, 4'd0, 4'd0}; b0.RREADY = 1;
        tick;
        chk("kept_40", 32'(b0.RDATA_OUT), 32'h0EE);
        chk("no_b_after", 32'(b0.BVALID), 0);
        b0.ARVALID = 0;
        tick;
        b0.ARVALID = 1; b0.AR = {8'h12, 4'd0, 4'd0};
        tick;
        chk("kept_12", 32'(b0.RDATA_OUT), 32'h186);
        b0.ARVALID = 0;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
